// File: rtl/axi_stream_slave_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg: definitions shared by the AXI-Stream receiver slice.
//   AXIS_DATA_W - default stream data width
//   axis_beat_t - one buffered beat: TLAST flag plus data word
//   rx_state_e  - framing FSM states (IDLE: packet not started, BODY: mid-packet)
// -----------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_BODY = 1'b1
    } rx_state_e;

endpackage

// File: rtl/axi_stream_slave_if.sv
// -----------------------------------------------------------------------------
// axi_stream_slave_if: AXI-Stream beat channel (tdata/tvalid/tlast/tready).
//   master modport - drives tdata/tvalid/tlast, receives tready
//   slave  modport - receives tdata/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
interface axi_stream_slave_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axi_stream_slave_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo: single-clock FIFO, DEPTH entries (power of two, >= 2).
//   clk, rst_n   - clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata  - write one entry (ignored when full)
//   pop, rdata   - rdata shows the head entry combinationally, zero when empty
//   full, empty  - occupancy flags
//   count        - entries held, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Gated so the head reads as zero when nothing is buffered (incl. after reset).
    assign rdata = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/axi_stream_slave.sv
// -----------------------------------------------------------------------------
// axi_stream_slave: AXI-Stream receiver for the frequency-meter measurement
// stream. Buffers beats in a small FIFO, forwards them on a valid/ready port and
// checks each packet against PKT_LEN beats.
//   clk, rst_n        - clock, asynchronous active-low reset
//   s (slave modport) - incoming stream: tdata, tvalid, tlast -> tready
//   out_data/out_last - FIFO head beat
//   out_valid/out_ready - local consumer handshake
//   len_err           - one-cycle pulse after a beat that breaks framing
//   busy              - packet in progress or FIFO non-empty
// Optional build macro AXIS_RX_STATS_EN adds:
//   pkt_count (16 b, wraps) - accepted TLAST beats
//   err_count (8 b, saturates) - len_err pulses
// -----------------------------------------------------------------------------
module axi_stream_slave
    import axis_pkg::*;
#(
    parameter int DATA_W  = AXIS_DATA_W,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_stream_slave_if.slave    s,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 len_err,
    output logic                 busy
`ifdef AXIS_RX_STATS_EN
    ,
    output logic [15:0]          pkt_count,
    output logic [7:0]           err_count
`endif
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];
    localparam logic [8:0]    PKT_LEN_C = 9'(PKT_LEN);
    localparam logic [0:0]    ST_IDLE   = RX_IDLE;
    localparam logic [0:0]    ST_BODY   = RX_BODY;

    logic [DATA_W:0] fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    logic [AW:0]     count_next;
    logic            s_tready_reg;
    logic            accept;
    logic            release_beat;

    logic [0:0]      state_reg, state_next;
    logic [7:0]      bcnt_reg, bcnt_next;
    logic [8:0]      bcnt_inc;
    logic            len_err_reg, len_err_next;

    // s_tready_reg already implies the FIFO has room; the extra term only keeps
    // a stray beat out of a full FIFO.
    assign accept       = s.tvalid && s_tready_reg && !fifo_full;
    assign release_beat = out_valid && out_ready;

    axis_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata ({s.tlast, s.tdata}),
        .pop   (release_beat),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy after this edge; tready registers "not full" from it so the
    // flag is correct in the very cycle the FIFO fills or drains.
    always_comb begin
        count_next = fifo_count;
        if (accept && !release_beat) begin
            count_next = fifo_count + CNT_ONE;
        end else if (!accept && release_beat) begin
            count_next = fifo_count - CNT_ONE;
        end
    end

    // Framing check: bcnt counts beats of the current packet including this one.
    always_comb begin
        state_next   = state_reg;
        bcnt_next    = bcnt_reg;
        len_err_next = 1'b0;
        bcnt_inc     = {1'b0, bcnt_reg} + 9'd1;
        if (accept) begin
            if (state_reg == ST_IDLE) begin
                if (s.tlast) begin
                    len_err_next = (PKT_LEN != 1);
                end else begin
                    state_next = ST_BODY;
                    bcnt_next  = 8'd1;
                end
            end else begin
                if (s.tlast) begin
                    state_next   = ST_IDLE;
                    bcnt_next    = 8'd0;
                    len_err_next = (bcnt_inc != PKT_LEN_C);
                end else begin
                    // Missing TLAST: flag it once, stay in BODY until TLAST arrives.
                    len_err_next = (bcnt_inc == PKT_LEN_C);
                    bcnt_next    = (bcnt_reg == 8'hFF) ? 8'hFF : bcnt_inc[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_tready_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            bcnt_reg     <= 8'd0;
            len_err_reg  <= 1'b0;
        end else begin
            s_tready_reg <= (count_next != CNT_FULL);
            state_reg    <= state_next;
            bcnt_reg     <= bcnt_next;
            len_err_reg  <= len_err_next;
        end
    end

    assign s.tready  = s_tready_reg;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[DATA_W-1:0];
    assign out_last  = fifo_rdata[DATA_W];
    assign len_err   = len_err_reg;
    assign busy      = (state_reg == ST_BODY) || !fifo_empty;

`ifdef AXIS_RX_STATS_EN
    logic [15:0] pkt_count_reg;
    logic [7:0]  err_count_reg;

    // err_count steps on the same edge that raises len_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_reg <= 16'd0;
            err_count_reg <= 8'd0;
        end else begin
            if (accept && s.tlast) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
            if (len_err_next && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign pkt_count = pkt_count_reg;
    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_axi_stream_slave.sv
`timescale 1ns/1ps
// Two receivers (PKT_LEN 1 and 3) share one stimulus stream; a queue model
// predicts every output and is pinned by hand-computed per-phase expectations.
module tb_axi_stream_slave;
    import axis_pkg::*;

    localparam int DEPTH = 4;
    localparam int NI    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        out_ready = 1'b0;
    logic        rdy_rand = 1'b0;
    logic        rdy_force = 1'b0;

    logic [31:0] out_data_w  [NI];
    logic        out_last_w  [NI];
    logic        out_valid_w [NI];
    logic        s_tready_w  [NI];
    logic        len_err_w   [NI];
    logic        busy_w      [NI];
`ifdef AXIS_RX_STATS_EN
    logic [15:0] pkt_count_w [NI];
    logic [7:0]  err_count_w [NI];
`endif

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        axi_stream_slave_if #(.DATA_W(32)) bus ();
        assign bus.tdata      = s_tdata;
        assign bus.tvalid     = s_tvalid;
        assign bus.tlast      = s_tlast;
        assign s_tready_w[gi] = bus.tready;

        axi_stream_slave #(
            .DATA_W  (32),
            .DEPTH   (DEPTH),
            .PKT_LEN ((gi == 0) ? 1 : 3)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .s         (bus.slave),
            .out_data  (out_data_w[gi]),
            .out_last  (out_last_w[gi]),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .len_err   (len_err_w[gi]),
            .busy      (busy_w[gi])
`ifdef AXIS_RX_STATS_EN
            ,
            .pkt_count (pkt_count_w[gi]),
            .err_count (err_count_w[gi])
`endif
        );
    end

    initial forever #5 clk = ~clk;

    // Consumer ready: forced level or 70% random, changed just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 99) < 70) : rdy_force;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %h, want %h", nm, i, $time, got, want);
        end
    endtask

    function automatic int plen(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ---------------- behavioural model ----------------
    logic [32:0] exp_q [$];
    logic [31:0] pop_log [$];
    int          pos [NI];
    bit          exp_err [NI];
    int          exp_errc [NI];
    int          exp_pkt;
    bit          armed;
    int          obs_err [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            pos[i] = 0; exp_err[i] = 0; exp_errc[i] = 0; obs_err[i] = 0;
        end
        exp_pkt = 0;
        armed = 0;
        forever begin
            bit rdy, push, pop;
            int p;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                for (int i = 0; i < NI; i++) begin
                    pos[i] = 0; exp_err[i] = 0; exp_errc[i] = 0;
                end
                exp_pkt = 0;
                armed = 0;
            end else begin
                rdy  = armed && (exp_q.size() < DEPTH);
                push = s_tvalid && rdy;
                pop  = out_ready && (exp_q.size() != 0);
                for (int i = 0; i < NI; i++) begin
                    exp_err[i] = 0;
                    if (push) begin
                        p = pos[i] + 1;
                        if (s_tlast) begin
                            exp_err[i] = (p != plen(i));
                            pos[i] = 0;
                        end else begin
                            // first beat of a packet is never flagged without TLAST
                            exp_err[i] = (p >= 2) && (p == plen(i));
                            pos[i] = p;
                        end
                    end
                    if (exp_err[i] && exp_errc[i] < 255) exp_errc[i]++;
                end
                if (push && s_tlast) exp_pkt = (exp_pkt + 1) & 16'hFFFF;
                if (pop) begin
                    pop_log.push_back(out_data_w[0]);
                    void'(exp_q.pop_front());
                end
                if (push) exp_q.push_back({s_tlast, s_tdata});
                armed = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk("s_tready", i, s_tready_w[i], armed && (exp_q.size() < DEPTH));
                chk("out_valid", i, out_valid_w[i], exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("out_data", i, out_data_w[i], exp_q[0][31:0]);
                    chk("out_last", i, out_last_w[i], exp_q[0][32]);
                end
                chk("len_err", i, len_err_w[i], exp_err[i]);
                chk("busy", i, busy_w[i], (exp_q.size() != 0) || (pos[i] != 0));
`ifdef AXIS_RX_STATS_EN
                chk("pkt_count", i, pkt_count_w[i], exp_pkt);
                chk("err_count", i, err_count_w[i], exp_errc[i]);
`endif
                obs_err[i] += len_err_w[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] d, input logic l, output int cyc);
        bit got;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            cyc++;
            got = s_tready_w[0];
        end
        if (!got) chk("send_accept", 0, got, 1);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain", 0, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_errs(input string nm, input int b0, input int b1, input int w0, input int w1);
        chk(nm, 0, obs_err[0] - b0, w0);
        chk(nm, 1, obs_err[1] - b1, w1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int c, acc, tot, e0, e1, ls;
        logic [31:0] d;

        // reset state
        wait_cycles(3);
        for (int i = 0; i < NI; i++) begin
            chk("rst_s_tready", i, s_tready_w[i], 0);
            chk("rst_out_valid", i, out_valid_w[i], 0);
            chk("rst_out_data", i, out_data_w[i], 0);
            chk("rst_out_last", i, out_last_w[i], 0);
            chk("rst_len_err", i, len_err_w[i], 0);
            chk("rst_busy", i, busy_w[i], 0);
        end
        rst_n = 1'b1;
        wait_cycles(1);
        chk("tready_rise", 0, s_tready_w[0], 1);

        // single beats, consumer always ready
        rdy_force = 1'b1;
        wait_cycles(2);
        e0 = obs_err[0]; e1 = obs_err[1]; ls = pop_log.size();
        send(32'hAABBCCDD, 1'b1, c);
        chk("lat_valid", 0, out_valid_w[0], 1);
        chk("lat_data", 0, out_data_w[0], 32'hAABBCCDD);
        send(32'h12341234, 1'b1, c);
        send(32'h55AA55AA, 1'b1, c);
        idle();
        drain();
        chk("p1_pop0", 0, pop_log[ls], 32'hAABBCCDD);
        chk("p1_pop1", 0, pop_log[ls+1], 32'h12341234);
        chk("p1_pop2", 0, pop_log[ls+2], 32'h55AA55AA);
        chk_errs("p1_errs", e0, e1, 0, 3);

        // backpressure fill: only DEPTH beats get in while the consumer stalls
        rdy_force = 1'b0;
        wait_cycles(2);
        e0 = obs_err[0]; e1 = obs_err[1]; ls = pop_log.size();
        acc = 0; d = 1;
        s_tdata = d; s_tlast = (d % 3 == 0); s_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (s_tready_w[0]) begin acc++; d++; end
            #1;
            s_tdata = d; s_tlast = (d % 3 == 0);
        end
        chk("bp_accepts", 0, acc, 4);
        chk("bp_tready_low", 0, s_tready_w[0], 0);
        rdy_force = 1'b1;
        while (d <= 6) begin
            send(d, (d % 3 == 0), c);
            d++;
        end
        idle();
        drain();
        for (int k = 0; k < 6; k++) chk("p2_pop", k, pop_log[ls+k], k + 1);
        chk_errs("p2_errs", e0, e1, 2, 0);

        // full FIFO with continuous stream: one beat per cycle across wrap
        rdy_force = 1'b0;
        wait_cycles(2);
        e0 = obs_err[0]; e1 = obs_err[1]; ls = pop_log.size();
        for (int k = 1; k <= 4; k++) send(32'h100 + k, (k % 3 == 0), c);
        rdy_force = 1'b1;
        send(32'h105, 1'b0, c);
        tot = 0;
        for (int k = 6; k <= 21; k++) begin
            send(32'h100 + k, (k % 3 == 0), c);
            tot += c;
        end
        chk("stream_cycles", 0, tot, 16);
        idle();
        drain();
        for (int k = 0; k < 21; k++) chk("p3_pop", k, pop_log[ls+k], 32'h101 + k);
        chk_errs("p3_errs", e0, e1, 7, 0);

        // framing errors: 2-beat packet, then 4-beat packet with TLAST late
        e0 = obs_err[0]; e1 = obs_err[1]; ls = pop_log.size();
        send(32'h201, 1'b0, c);
        send(32'h202, 1'b1, c);
        chk("short_pkt_err", 1, len_err_w[1], 1);
        chk("short_pkt_err", 0, len_err_w[0], 1);
        send(32'h203, 1'b0, c);
        chk("new_pkt_no_err", 1, len_err_w[1], 0);
        send(32'h204, 1'b0, c);
        send(32'h205, 1'b0, c);
        chk("missing_last_err", 1, len_err_w[1], 1);
        send(32'h206, 1'b1, c);
        idle();
        drain();
        for (int k = 0; k < 6; k++) chk("p4_pop", k, pop_log[ls+k], 32'h201 + k);
        chk_errs("p4_errs", e0, e1, 2, 3);

        // reset in the middle of a packet with two beats buffered
        rdy_force = 1'b0;
        wait_cycles(2);
        e0 = obs_err[0]; e1 = obs_err[1];
        send(32'h301, 1'b1, c);
        send(32'h302, 1'b0, c);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("mid_rst_s_tready", i, s_tready_w[i], 0);
            chk("mid_rst_out_valid", i, out_valid_w[i], 0);
            chk("mid_rst_out_data", i, out_data_w[i], 0);
            chk("mid_rst_busy", i, busy_w[i], 0);
            chk("mid_rst_len_err", i, len_err_w[i], 0);
`ifdef AXIS_RX_STATS_EN
            chk("mid_rst_pkt_count", i, pkt_count_w[i], 0);
            chk("mid_rst_err_count", i, err_count_w[i], 0);
`endif
        end
        wait_cycles(2);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        wait_cycles(2);
        ls = pop_log.size();
        send(32'h311, 1'b0, c);
        send(32'h312, 1'b0, c);
        send(32'h313, 1'b1, c);
        idle();
        drain();
        chk("p5_first_after_rst", 0, pop_log[ls], 32'h311);
        chk_errs("p5_errs", e0, e1, 1, 1);

        // random consumer ready, 67 packets of 3 beats
        e0 = obs_err[0]; e1 = obs_err[1]; ls = pop_log.size();
        rdy_rand = 1'b1;
        for (int k = 0; k < 201; k++) send($urandom, (k % 3 == 2), c);
        idle();
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        drain();
        chk("p6_pops", 0, pop_log.size() - ls, 201);
        chk_errs("p6_errs", e0, e1, 67, 0);
`ifdef AXIS_RX_STATS_EN
        chk("final_pkt_count", 0, pkt_count_w[0], 68);
        chk("final_pkt_count", 1, pkt_count_w[1], 68);
        chk("final_err_count", 0, err_count_w[0], 68);
        chk("final_err_count", 1, err_count_w[1], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
